mux_function_tester: RTL and testbench

- Self-checking stimulus/response engine for the 3-input function block F = (A & ~B) | (B & C).
- Drives A/B/C, then samples all three implementation outputs (structural, functional, behavioral) and compares each against an internal golden model.
- Sits on the opposite side of the block's interface: it generates the block's inputs and consumes its outputs.
- Used on-board, with result LEDs, and in simulation as a reusable exhaustive checker.

---
 rtl/mux_function_tester.sv | 151 +++++++++++++++
 tb/tb_mux_function_tester.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_function_tester.sv
// Exhaustive stimulus/response checker for F = (A & ~B) | (B & C).
// Sweeps {A,B,C} from 000 to 111, holds each vector for SETTLE_CYCLES cycles,
// then samples the structural, functional and behavioral outputs of the block
// under test in one CHECK cycle and accumulates mismatch results.
// SETTLE_CYCLES must lie in 1..15 (the settle counter is 4 bits wide).
module mux_function_tester #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             A_out,
  output logic             B_out,
  output logic             C_out,
  input  logic             f_struct_in,
  input  logic             f_func_in,
  input  logic             f_behav_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [2:0]       err_mask,
  output logic [2:0]       first_err_vec,
  output logic             first_err_valid
);

  localparam int unsigned VEC_W  = 3;
  localparam int unsigned SCNT_W = 4;

  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(SETTLE_CYCLES - 1);
  localparam logic [VEC_W-1:0]  VEC_LAST  = {VEC_W{1'b1}};
  localparam logic [ERR_W-1:0]  ERR_MAX   = {ERR_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t             r_state;
  logic [VEC_W-1:0]   r_vec;
  logic [SCNT_W-1:0]  r_scnt;
  logic               r_busy;
  logic               r_done;
  logic               r_pass;
  logic [ERR_W-1:0]   r_err_count;
  logic [2:0]         r_err_mask;
  logic [VEC_W-1:0]   r_first_err_vec;
  logic               r_first_err_valid;

  logic               w_exp;
  logic [2:0]         w_mism;
  logic               w_any_mism;
  logic [ERR_W-1:0]   w_err_next;

  // Golden model of the function for the vector currently driven.
  assign w_exp = (r_vec[2] & ~r_vec[1]) | (r_vec[1] & r_vec[0]);

  // Per-output mismatch flags: [2] structural, [1] functional, [0] behavioral.
  assign w_mism     = {f_struct_in ^ w_exp, f_func_in ^ w_exp, f_behav_in ^ w_exp};
  assign w_any_mism = |w_mism;

  // Saturating error count as it will be after the current CHECK cycle.
  always_comb begin
    w_err_next = r_err_count;
    if (w_any_mism && (r_err_count != ERR_MAX)) begin
      w_err_next = r_err_count + ERR_W'(1);
    end
  end

  // Sweep sequencer with registered status and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state           <= ST_IDLE;
      r_vec             <= '0;
      r_scnt            <= '0;
      r_busy            <= 1'b0;
      r_done            <= 1'b0;
      r_pass            <= 1'b0;
      r_err_count       <= '0;
      r_err_mask        <= '0;
      r_first_err_vec   <= '0;
      r_first_err_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          // A start from DONE is a restart with the same clearing as from IDLE.
          if (start) begin
            r_state           <= ST_SETTLE;
            r_vec             <= '0;
            r_scnt            <= '0;
            r_busy            <= 1'b1;
            r_done            <= 1'b0;
            r_pass            <= 1'b0;
            r_err_count       <= '0;
            r_err_mask        <= '0;
            r_first_err_vec   <= '0;
            r_first_err_valid <= 1'b0;
          end
        end

        ST_SETTLE: begin
          if (r_scnt == SCNT_LAST) begin
            r_state <= ST_CHECK;
            r_scnt  <= '0;
          end else begin
            r_scnt  <= r_scnt + SCNT_W'(1);
          end
        end

        ST_CHECK: begin
          r_err_mask  <= r_err_mask | w_mism;
          r_err_count <= w_err_next;
          if (w_any_mism && !r_first_err_valid) begin
            r_first_err_vec   <= r_vec;
            r_first_err_valid <= 1'b1;
          end
          if (r_vec == VEC_LAST) begin
            // Last vector: vec holds at 111 and results freeze in DONE.
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_next == '0);
          end else begin
            r_state <= ST_SETTLE;
            r_vec   <= r_vec + VEC_W'(1);
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Stimulus comes straight from the vector register, so it is glitch-free.
  assign A_out           = r_vec[2];
  assign B_out           = r_vec[1];
  assign C_out           = r_vec[0];
  assign busy            = r_busy;
  assign done            = r_done;
  assign pass            = r_pass;
  assign err_count       = r_err_count;
  assign err_mask        = r_err_mask;
  assign first_err_vec   = r_first_err_vec;
  assign first_err_valid = r_first_err_valid;

endmodule

// File: tb/tb_mux_function_tester.sv
// Bench for mux_function_tester: two checker instances (ERR_W=4 and ERR_W=2)
// each look at a block-under-test modelled as three 8-entry truth tables.
module tb_mux_function_tester;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  // Truth tables of the modelled block outputs, indexed by {A,B,C}.
  logic [7:0] t1s, t1f, t1b, t2s, t2f, t2b;

  logic a1, b1, c1, busy1, done1, pass1, fval1;
  logic [3:0] err1;
  logic [2:0] msk1, fv1;
  logic a2, b2, c2, busy2, done2, pass2, fval2;
  logic [1:0] err2;
  logic [2:0] msk2, fv2;
  logic [2:0] idx1, idx2;
  logic fs1, ff1, fb1, fs2, ff2, fb2;

  assign idx1 = {a1, b1, c1};
  assign idx2 = {a2, b2, c2};
  assign fs1 = t1s[idx1];
  assign ff1 = t1f[idx1];
  assign fb1 = t1b[idx1];
  assign fs2 = t2s[idx2];
  assign ff2 = t2f[idx2];
  assign fb2 = t2b[idx2];

  mux_function_tester #(.SETTLE_CYCLES(2), .ERR_W(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .A_out(a1), .B_out(b1), .C_out(c1),
    .f_struct_in(fs1), .f_func_in(ff1), .f_behav_in(fb1),
    .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .err_mask(msk1),
    .first_err_vec(fv1), .first_err_valid(fval1)
  );

  mux_function_tester #(.SETTLE_CYCLES(2), .ERR_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start),
    .A_out(a2), .B_out(b2), .C_out(c2),
    .f_struct_in(fs2), .f_func_in(ff2), .f_behav_in(fb2),
    .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .err_mask(msk2),
    .first_err_vec(fv2), .first_err_valid(fval2)
  );

  // The function is 1 exactly for vectors 3, 4, 5 and 7.
  function automatic logic golden(input int v);
    return (v == 3) || (v == 4) || (v == 5) || (v == 7);
  endfunction

  // Expected sweep results for a set of truth tables.
  task automatic model(input logic [7:0] ts, input logic [7:0] tf, input logic [7:0] tb,
                       input int maxc, output int cnt, output logic [2:0] msk,
                       output logic [2:0] fv, output logic fval);
    cnt = 0; msk = 3'b000; fv = 3'b000; fval = 1'b0;
    for (int v = 0; v < 8; v++) begin
      logic [2:0] m;
      m = {ts[v] != golden(v), tf[v] != golden(v), tb[v] != golden(v)};
      msk = msk | m;
      if (m != 3'b000) begin
        if (cnt < maxc) cnt = cnt + 1;
        if (!fval) begin
          fv = 3'(v);
          fval = 1'b1;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_chk++;
    if ({a1, b1, c1, busy1, done1, pass1, fval1, err1, msk1, fv1} !== 17'd0) begin
      n_err++;
      $display("FAIL reset_dut1: got %b required all zero",
               {a1, b1, c1, busy1, done1, pass1, fval1, err1, msk1, fv1});
    end
    n_chk++;
    if ({a2, b2, c2, busy2, done2, pass2, fval2, err2, msk2, fv2} !== 15'd0) begin
      n_err++;
      $display("FAIL reset_dut2: got %b required all zero",
               {a2, b2, c2, busy2, done2, pass2, fval2, err2, msk2, fv2});
    end
    rst = 1'b0;
    tick();
    n_chk++;
    if ({busy1, done1} !== 2'b00) begin
      n_err++;
      $display("FAIL idle_no_start: busy/done got %b required 00", {busy1, done1});
    end
  endtask

  // Runs one sweep; ign_cycle >= 0 re-pulses start at that cycle (must be ignored).
  task automatic run_sweep(input string name, input int ign_cycle);
    int cyc;
    int cnt1, cnt2;
    logic [2:0] em1, ef1, em2, ef2;
    logic ev1, ev2;
    logic [2:0] ev;
    model(t1s, t1f, t1b, 15, cnt1, em1, ef1, ev1);
    model(t2s, t2f, t2b, 3, cnt2, em2, ef2, ev2);
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (!done1 && cyc < 100) begin
      ev = 3'((cyc / 3 > 7) ? 7 : cyc / 3);
      n_chk++;
      if ({a1, b1, c1, busy1, done1, pass1} !== {ev, 3'b100}) begin
        n_err++;
        $display("FAIL %s stim_cyc%0d: got abc/busy/done/pass=%b required %b",
                 name, cyc, {a1, b1, c1, busy1, done1, pass1}, {ev, 3'b100});
      end
      start = (cyc == ign_cycle);
      tick();
      start = 1'b0;
      cyc++;
    end
    n_chk++;
    if (cyc != 24 || !done1) begin
      n_err++;
      $display("FAIL %s done_latency: got %0d cycles (done=%b) required 24", name, cyc, done1);
    end
    n_chk++;
    if ({done2, busy2, a2, b2, c2} !== 5'b10111) begin
      n_err++;
      $display("FAIL %s dut2_done: got done/busy/abc=%b required 10111", name,
               {done2, busy2, a2, b2, c2});
    end
    repeat (3) tick();
    n_chk++;
    if ({done1, busy1, a1, b1, c1} !== 5'b10111) begin
      n_err++;
      $display("FAIL %s done_hold: got done/busy/abc=%b required 10111", name,
               {done1, busy1, a1, b1, c1});
    end
    n_chk++;
    if (err1 !== 4'(cnt1)) begin
      n_err++; $display("FAIL %s err_count1: got %0d required %0d", name, err1, cnt1);
    end
    n_chk++;
    if (msk1 !== em1) begin
      n_err++; $display("FAIL %s err_mask1: got %b required %b", name, msk1, em1);
    end
    n_chk++;
    if ({fval1, fv1} !== {ev1, ef1}) begin
      n_err++; $display("FAIL %s first_err1: got %b/%b required %b/%b", name, fval1, fv1, ev1, ef1);
    end
    n_chk++;
    if (pass1 !== (cnt1 == 0)) begin
      n_err++; $display("FAIL %s pass1: got %b required %b", name, pass1, cnt1 == 0);
    end
    n_chk++;
    if (err2 !== 2'(cnt2)) begin
      n_err++; $display("FAIL %s err_count2: got %0d required %0d", name, err2, cnt2);
    end
    n_chk++;
    if (msk2 !== em2) begin
      n_err++; $display("FAIL %s err_mask2: got %b required %b", name, msk2, em2);
    end
    n_chk++;
    if ({fval2, fv2} !== {ev2, ef2}) begin
      n_err++; $display("FAIL %s first_err2: got %b/%b required %b/%b", name, fval2, fv2, ev2, ef2);
    end
    n_chk++;
    if (pass2 !== (cnt2 == 0)) begin
      n_err++; $display("FAIL %s pass2: got %b required %b", name, pass2, cnt2 == 0);
    end
  endtask

  task automatic set_tables(input logic [7:0] s1, input logic [7:0] f1, input logic [7:0] b1v,
                            input logic [7:0] s2, input logic [7:0] f2, input logic [7:0] b2v);
    t1s = s1; t1f = f1; t1b = b1v;
    t2s = s2; t2f = f2; t2b = b2v;
  endtask

  task automatic test_correct();
    set_tables(8'hB8, 8'hB8, 8'hB8, 8'hB8, 8'hB8, 8'hB8);
    run_sweep("correct", -1);
  endtask

  task automatic test_struct_stuck();
    set_tables(8'h00, 8'hB8, 8'hB8, 8'hB8, 8'h00, 8'hB8);
    run_sweep("struct_stuck0", -1);
  endtask

  task automatic test_func_no_c();
    set_tables(8'hB8, 8'h30, 8'hB8, 8'hB8, 8'hB8, 8'h30);
    run_sweep("func_no_c", -1);
  endtask

  task automatic test_saturate();
    set_tables(8'h47, 8'h47, 8'h47, 8'h47, 8'h47, 8'h47);
    run_sweep("all_inverted", -1);
  endtask

  task automatic test_reset_mid();
    int cyc;
    int exp_cnt;
    set_tables(8'h00, 8'hB8, 8'hB8, 8'hB8, 8'hB8, 8'hB8);
    exp_cnt = 0;
    for (int v = 0; v < 5; v++) if (golden(v)) exp_cnt++;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (cyc < 17) begin
      tick();
      cyc++;
    end
    n_chk++;
    if ({a1, b1, c1, busy1, err1} !== {3'b101, 1'b1, 4'(exp_cnt)}) begin
      n_err++;
      $display("FAIL reset_mid_pre: got abc/busy/err=%b required %b",
               {a1, b1, c1, busy1, err1}, {3'b101, 1'b1, 4'(exp_cnt)});
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_chk++;
    if ({a1, b1, c1, busy1, done1, pass1, err1, msk1, fval1} !== 14'd0) begin
      n_err++;
      $display("FAIL reset_mid_post: got %b required all zero",
               {a1, b1, c1, busy1, done1, pass1, err1, msk1, fval1});
    end
    tick();
    n_chk++;
    if ({busy1, done1, busy2, done2} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_mid_idle: got %b required 0000", {busy1, done1, busy2, done2});
    end
    run_sweep("after_reset", -1);
  endtask

  task automatic test_mid_start();
    set_tables(8'hB8, 8'hB9, 8'hB8, 8'hB8, 8'hB8, 8'hFF);
    run_sweep("mid_start", 10);
    run_sweep("late_start", 23);
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      logic [7:0] tb6 [6];
      for (int k = 0; k < 6; k++) begin
        tb6[k] = ($urandom_range(0, 2) == 0) ? 8'hB8 : 8'($urandom);
      end
      set_tables(tb6[0], tb6[1], tb6[2], tb6[3], tb6[4], tb6[5]);
      run_sweep($sformatf("random%0d", i), int'($urandom_range(0, 30)) - 6);
    end
  endtask

  initial begin
    set_tables(8'hB8, 8'hB8, 8'hB8, 8'hB8, 8'hB8, 8'hB8);
    test_reset();
    test_correct();
    test_struct_stuck();
    test_func_no_c();
    test_saturate();
    test_reset_mid();
    test_mid_start();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
